// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache fills, D-cache fills and D-cache
// write-through stores onto a single-ported, pipelined 4-cycle main memory.
// A fill issues every word read of the block back-to-back. Returned words
// are steered into the selected cache's data array through a one-hot word
// enable. The tag write and the done pulse fire on the last returned word.

module mem_arbiter #(
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_miss,
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic                   d_miss,
    input  logic [ADDR_W-1:0]      d_addr,
    input  logic                   d_wr,
    input  logic [15:0]            d_wdata,
    input  logic [15:0]            mem_data_out,
    input  logic                   mem_data_valid,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [15:0]            mem_data_in,
    output logic                   mem_enable,
    output logic                   mem_wr,
    output logic                   fill_sel,
    output logic [BLOCK_WORDS-1:0] fill_word_en,
    output logic [15:0]            fill_data,
    output logic                   fill_write_data,
    output logic                   fill_write_tag,
    output logic                   i_done,
    output logic                   d_done,
    output logic                   busy
);

    // Issue counter must reach BLOCK_WORDS itself to mark "all issued";
    // the return counter only ever indexes a word inside the block.
    localparam int unsigned RET_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned ISS_W = $clog2(BLOCK_WORDS + 1);

    localparam logic [ISS_W-1:0]       ISS_END  = ISS_W'(BLOCK_WORDS);
    localparam logic [RET_W-1:0]       RET_LAST = RET_W'(BLOCK_WORDS - 1);
    // Byte offset bits inside a block (2 bytes per word).
    localparam logic [ADDR_W-1:0]      OFS_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [BLOCK_WORDS-1:0] WEN_ONE  = BLOCK_WORDS'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IFILL  = 2'd1;
    localparam logic [1:0] S_DFILL  = 2'd2;
    localparam logic [1:0] S_DWRITE = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [ISS_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [RET_W-1:0]  ret_cnt_q,   ret_cnt_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              fill_sel_q,  fill_sel_d;

    logic in_fill;
    logic issuing;
    logic ret_fire;
    logic ret_last;

    // Fill-phase qualifiers shared by next-state and output logic.
    always_comb begin
        in_fill  = (state_q == S_IFILL) || (state_q == S_DFILL);
        issuing  = in_fill && (issue_cnt_q < ISS_END);
        ret_fire = in_fill && mem_data_valid;
        ret_last = ret_fire && (ret_cnt_q == RET_LAST);
    end

    // Next-state: fixed-priority arbitration in IDLE, counter stepping in fills.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        addr_d      = addr_q;
        fill_sel_d  = fill_sel_q;

        case (state_q)
            S_IDLE: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (d_wr) begin
                    state_d = S_DWRITE;
                    addr_d  = d_addr;
                end else if (d_miss) begin
                    state_d    = S_DFILL;
                    addr_d     = d_addr & ~OFS_MASK;
                    fill_sel_d = 1'b1;
                end else if (i_miss) begin
                    state_d    = S_IFILL;
                    addr_d     = i_addr & ~OFS_MASK;
                    fill_sel_d = 1'b0;
                end
            end

            S_IFILL, S_DFILL: begin
                if (issuing) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (ret_fire) begin
                    ret_cnt_d = ret_cnt_q + 1'b1;
                end
                if (ret_last) begin
                    state_d     = S_IDLE;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end

            S_DWRITE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset;
    // a reset mid-transaction simply abandons it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            addr_q      <= '0;
            fill_sel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            addr_q      <= addr_d;
            fill_sel_q  <= fill_sel_d;
        end
    end

    // Outputs: memory strobes from state/counters, fill strobes follow
    // mem_data_valid combinationally so each word lands in its return cycle.
    always_comb begin
        mem_addr        = '0;
        mem_data_in     = '0;
        mem_enable      = 1'b0;
        mem_wr          = 1'b0;
        fill_word_en    = '0;
        fill_data       = '0;
        fill_write_data = 1'b0;
        fill_write_tag  = 1'b0;
        i_done          = 1'b0;
        d_done          = 1'b0;
        fill_sel        = fill_sel_q;
        busy            = (state_q != S_IDLE);

        case (state_q)
            S_DWRITE: begin
                mem_enable  = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = addr_q;
                mem_data_in = d_wdata;
                d_done      = 1'b1;
            end

            S_IFILL, S_DFILL: begin
                if (issuing) begin
                    mem_enable = 1'b1;
                    mem_addr   = addr_q + (ADDR_W'(issue_cnt_q) << 1);
                end
                if (ret_fire) begin
                    fill_write_data = 1'b1;
                    fill_data       = mem_data_out;
                    fill_word_en    = WEN_ONE << ret_cnt_q;
                end
                if (ret_last) begin
                    fill_write_tag = 1'b1;
                    i_done         = (state_q == S_IFILL);
                    d_done         = (state_q == S_DFILL);
                end
            end

            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 4-cycle pipelined memory model,
// a cycle-vector table (reset, fill start, reset abort), hand sequences
// for fills, priority and back-to-back cases, and a randomized phase
// checked by a transaction-level reference model.

module tb_mem_arbiter;

    localparam int unsigned BW = 8;
    localparam int unsigned AW = 16;

    logic          clk;
    logic          rst;
    logic          i_miss;
    logic [15:0]   i_addr;
    logic          d_miss;
    logic [15:0]   d_addr;
    logic          d_wr;
    logic [15:0]   d_wdata;
    logic [15:0]   mem_data_out;
    logic          mem_data_valid;
    logic [15:0]   mem_addr;
    logic [15:0]   mem_data_in;
    logic          mem_enable;
    logic          mem_wr;
    logic          fill_sel;
    logic [7:0]    fill_word_en;
    logic [15:0]   fill_data;
    logic          fill_write_data;
    logic          fill_write_tag;
    logic          i_done;
    logic          d_done;
    logic          busy;

    mem_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss         (i_miss),
        .i_addr         (i_addr),
        .d_miss         (d_miss),
        .d_addr         (d_addr),
        .d_wr           (d_wr),
        .d_wdata        (d_wdata),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .fill_sel       (fill_sel),
        .fill_word_en   (fill_word_en),
        .fill_data      (fill_data),
        .fill_write_data(fill_write_data),
        .fill_write_tag (fill_write_tag),
        .i_done         (i_done),
        .d_done         (d_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        busy;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        fsel;
        logic [7:0]  wen;
        logic [15:0] fdata;
        logic        fwd;
        logic        tag;
        logic        idone;
        logic        ddone;
    } outs_t;

    typedef struct {
        logic        rst;
        logic        im;
        logic        dm;
        logic        dw;
        logic [15:0] ia;
        logic [15:0] da;
        logic [15:0] wd;
        outs_t       exp;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        o.busy  = busy;
        o.en    = mem_enable;
        o.wr    = mem_wr;
        o.addr  = mem_addr;
        o.din   = mem_data_in;
        o.fsel  = fill_sel;
        o.wen   = fill_word_en;
        o.fdata = fill_data;
        o.fwd   = fill_write_data;
        o.tag   = fill_write_tag;
        o.idone = i_done;
        o.ddone = d_done;
        return o;
    endfunction

    function automatic outs_t idle_outs(input logic fs);
        outs_t o;
        o      = '0;
        o.fsel = fs;
        return o;
    endfunction

    // ---------------- memory model (4-cycle read latency) ----------------
    logic [15:0] memw [logic [15:0]];

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (memw.exists(a)) return memw[a];
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    logic        dv [4];
    logic [15:0] dd [4];

    initial begin : memory_model
        logic        cap_v;
        logic [15:0] cap_d;
        mem_data_valid = 1'b0;
        mem_data_out   = '0;
        for (int i = 0; i < 4; i++) begin
            dv[i] = 1'b0;
            dd[i] = '0;
        end
        forever begin
            @(negedge clk);
            cap_v = mem_enable && !mem_wr;
            cap_d = rd(mem_addr);
            if (mem_enable && mem_wr) memw[mem_addr] = mem_data_in;
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                dv[i] = dv[i-1];
                dd[i] = dd[i-1];
            end
            dv[0] = cap_v;
            dd[0] = cap_d;
            mem_data_valid = dv[3];
            mem_data_out   = dv[3] ? dd[3] : 16'($urandom);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // One full fill starting at its cycle 0 (called at posedge+1); drops the
    // owning request after the done cycle and returns at posedge+1 of cycle 12.
    task automatic run_fill(input logic isd, input logic [15:0] base, input int dwr_at);
        outs_t      e;
        logic [7:0] one8;
        one8 = 8'd1;
        for (int k = 0; k < 12; k++) begin
            if (k == dwr_at) d_wr = 1'b1;
            @(negedge clk);
            e      = '0;
            e.busy = 1'b1;
            e.fsel = isd;
            if (k < 8) begin
                e.en   = 1'b1;
                e.addr = base + 16'(2 * k);
            end
            if (k >= 4) begin
                e.fwd   = 1'b1;
                e.wen   = one8 << (k - 4);
                e.fdata = rd(base + 16'(2 * (k - 4)));
            end
            if (k == 11) begin
                e.tag = 1'b1;
                if (isd) e.ddone = 1'b1;
                else     e.idone = 1'b1;
            end
            chk($sformatf("%s_c%0d", isd ? "dfill" : "ifill", k), sample(), e);
            @(posedge clk);
            #1;
            if (k == 11) begin
                if (isd) d_miss = 1'b0;
                else     i_miss = 1'b0;
            end
        end
    endtask

    task automatic idle_chk(input string name, input logic fs);
        @(negedge clk);
        chk(name, sample(), idle_outs(fs));
        @(posedge clk);
        #1;
    endtask

    task automatic dwrite_chk(input string name, input logic [15:0] a, input logic [15:0] wd, input logic fs);
        outs_t e;
        @(negedge clk);
        e       = '0;
        e.busy  = 1'b1;
        e.en    = 1'b1;
        e.wr    = 1'b1;
        e.addr  = a;
        e.din   = wd;
        e.fsel  = fs;
        e.ddone = 1'b1;
        chk(name, sample(), e);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        vec_t        tbl [15];
        logic [7:0]  one8;
        int          kind;
        logic [15:0] m_base;
        logic [15:0] m_addr;
        logic [15:0] m_wd;
        int          n_iss;
        int          n_ret;
        int          age;
        logic        last;
        logic        drop_i;
        logic        drop_dm;
        logic        drop_dw;
        logic        raise_on;
        int          r;

        one8    = 8'd1;
        rst     = 1'b0;
        i_miss  = 1'b0;
        d_miss  = 1'b0;
        d_wr    = 1'b0;
        i_addr  = '0;
        d_addr  = '0;
        d_wdata = '0;

        // ---- table: reset with pending i_miss, fill start, reset at cycle 6 ----
        for (int i = 0; i < 15; i++) begin
            tbl[i].rst = 1'b1;
            tbl[i].im  = 1'b0;
            tbl[i].dm  = 1'b0;
            tbl[i].dw  = 1'b0;
            tbl[i].ia  = 16'h1236;
            tbl[i].da  = 16'h0000;
            tbl[i].wd  = 16'h0000;
            tbl[i].exp = idle_outs(1'b0);
        end
        tbl[0].rst = 1'b0; tbl[0].im = 1'b1;
        tbl[1].rst = 1'b0; tbl[1].im = 1'b1;
        tbl[2].im  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tbl[3+k].im       = 1'b1;
            tbl[3+k].exp.busy = 1'b1;
            tbl[3+k].exp.en   = 1'b1;
            tbl[3+k].exp.addr = 16'h1230 + 16'(2 * k);
            if (k >= 4) begin
                tbl[3+k].exp.fwd   = 1'b1;
                tbl[3+k].exp.wen   = one8 << (k - 4);
                tbl[3+k].exp.fdata = rd(16'h1230 + 16'(2 * (k - 4)));
            end
        end
        tbl[9].rst  = 1'b0;
        tbl[9].im   = 1'b0;
        tbl[10].rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            rst     = tbl[i].rst;
            i_miss  = tbl[i].im;
            d_miss  = tbl[i].dm;
            d_wr    = tbl[i].dw;
            i_addr  = tbl[i].ia;
            d_addr  = tbl[i].da;
            d_wdata = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), sample(), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // ---- full I-fill of 0x1236 ----
        i_addr = 16'h1236;
        i_miss = 1'b1;
        idle_chk("ifill_req_idle", 1'b0);
        run_fill(1'b0, 16'h1230, -1);
        idle_chk("ifill_end_idle", 1'b0);

        // ---- simultaneous d_wr, d_miss, i_miss ----
        d_addr  = 16'h0040;
        d_wdata = 16'hBEEF;
        i_addr  = 16'h2468;
        d_wr    = 1'b1;
        d_miss  = 1'b1;
        i_miss  = 1'b1;
        idle_chk("prio_req_idle", 1'b0);
        dwrite_chk("prio_dwrite", 16'h0040, 16'hBEEF, 1'b0);
        d_wr = 1'b0;
        idle_chk("prio_gap1", 1'b0);
        run_fill(1'b1, 16'h0040, -1);
        idle_chk("prio_gap2", 1'b1);
        run_fill(1'b0, 16'h2460, -1);
        idle_chk("prio_end", 1'b0);

        // ---- d_wr raised mid I-fill waits for i_done ----
        d_addr  = 16'h0100;
        d_wdata = 16'h1357;
        i_addr  = 16'h0F0A;
        i_miss  = 1'b1;
        idle_chk("late_wr_req_idle", 1'b0);
        run_fill(1'b0, 16'h0F00, 3);
        idle_chk("late_wr_gap", 1'b0);
        dwrite_chk("late_wr_dwrite", 16'h0100, 16'h1357, 1'b0);
        d_wr = 1'b0;
        idle_chk("late_wr_end", 1'b0);

        // ---- randomized traffic against a transaction-level model ----
        kind     = 0;   // 0 idle, 1 I-fill, 2 D-fill, 3 D-write
        m_base   = '0;
        m_addr   = '0;
        m_wd     = '0;
        n_iss    = 0;
        n_ret    = 0;
        age      = 0;
        drop_i   = 1'b0;
        drop_dm  = 1'b0;
        drop_dw  = 1'b0;
        raise_on = 1'b1;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            if (cyc == 3000) raise_on = 1'b0;
            if (raise_on && !i_miss && !drop_i && $urandom_range(0, 3) == 0) begin
                i_addr = 16'($urandom_range(0, 255));
                i_miss = 1'b1;
            end
            if (raise_on && !d_miss && !d_wr && !drop_dm && !drop_dw) begin
                r = int'($urandom_range(0, 9));
                if (r <= 2) d_addr = 16'($urandom_range(0, 255));
                if (r == 0 || r == 2) begin
                    d_wdata = 16'($urandom);
                    d_wr    = 1'b1;
                end
                if (r == 1 || r == 2) d_miss = 1'b1;
            end

            @(negedge clk);
            if (kind == 0) begin
                chk("r_idle", {busy, mem_enable, fill_write_data, fill_write_tag, i_done, d_done}, 64'd0);
                n_iss = 0;
                n_ret = 0;
                age   = 0;
                if (d_wr) begin
                    kind   = 3;
                    m_addr = d_addr;
                    m_wd   = d_wdata;
                end else if (d_miss) begin
                    kind   = 2;
                    m_base = d_addr & 16'hFFF0;
                end else if (i_miss) begin
                    kind   = 1;
                    m_base = i_addr & 16'hFFF0;
                end
            end else if (kind == 3) begin
                chk("r_dwrite", {busy, mem_enable, mem_wr, mem_addr, mem_data_in, d_done, i_done, fill_write_data},
                    {1'b1, 1'b1, 1'b1, m_addr, m_wd, 1'b1, 1'b0, 1'b0});
                kind = 0;
            end else begin
                chk("r_fill_ctl", {busy, fill_sel, mem_enable, mem_wr},
                    {1'b1, (kind == 2), (n_iss < 8), 1'b0});
                if (mem_enable) begin
                    chk("r_issue_addr", mem_addr, m_base + 16'(2 * n_iss));
                    n_iss++;
                end
                chk("r_ret_strobe", fill_write_data, mem_data_valid);
                last = 1'b0;
                if (fill_write_data) begin
                    chk("r_ret_word", {fill_word_en, fill_data},
                        {one8 << n_ret, rd(m_base + 16'(2 * n_ret))});
                    n_ret++;
                    last = (n_ret == 8);
                end
                chk("r_done", {fill_write_tag, i_done, d_done},
                    {last, last && (kind == 1), last && (kind == 2)});
                age++;
                if (last) begin
                    kind = 0;
                end else if (age > 30) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL r_timeout got=age%0d exp=fill_done_by_12", age);
                    kind = 0;
                end
            end
            drop_i  = i_done && i_miss;
            drop_dw = d_done && d_wr && mem_wr;
            drop_dm = d_done && d_miss && !mem_wr;

            @(posedge clk);
            #1;
            if (drop_i)  i_miss = 1'b0;
            if (drop_dw) d_wr   = 1'b0;
            if (drop_dm) d_miss = 1'b0;
            if (!raise_on && !i_miss && !d_miss && !d_wr && kind == 0) break;
        end
        chk("r_drain", {i_miss, d_miss, d_wr, 1'(kind != 0)}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the I-cache/D-cache miss logic and the single-ported 4-cycle main memory (memory4c).
- Arbitrates the two caches' fill requests and D-cache write-through stores, one transaction at a time.
- For a fill, it issues the block's word reads back-to-back and steers returned words into the selected cache's data array via one-hot word enables.
- It pulses the tag-array write when the last word returns.

Parameters:
BLOCK_WORDS, 8, words per cache block (16-byte block, 16-bit words)
ADDR_W, 16, byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
i_miss  in  1  I-cache fill request, level, held until i_done
i_addr  in  16  I-cache miss byte address
d_miss  in  1  D-cache fill request, level, held until d_done
d_addr  in  16  D-cache miss/store byte address
d_wr  in  1  D-cache write-through store request, level, held until d_done
d_wdata  in  16  store data
mem_data_out  in  16  memory read data
mem_data_valid  in  1  memory read data valid
mem_addr  out  16  memory address
mem_data_in  out  16  memory write data
mem_enable  out  1  memory access strobe
mem_wr  out  1  memory write strobe
fill_sel  out  1  fill target: 0=I-cache, 1=D-cache
fill_word_en  out  8  one-hot data-array word enable
fill_data  out  16  word to write into data array
fill_write_data  out  1  data-array write strobe
fill_write_tag  out  1  tag-array write strobe
i_done  out  1  one-cycle I-cache transaction complete
d_done  out  1  one-cycle D-cache transaction complete
busy  out  1  arbiter not in IDLE

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, issue_cnt=0, ret_cnt=0, all outputs 0. Reset mid-transaction aborts it with no done pulse. Late mem_data_valid after reset is ignored.
- States: IDLE, IFILL, DFILL, DWRITE.
- IDLE priority, evaluated each cycle: d_wr -> DWRITE; else d_miss -> DFILL; else i_miss -> IFILL.
  - Request addresses are latched on entry to the new state.
  - A fill latches the block base = addr & 16'hFFF0.
- DWRITE, one cycle: mem_enable=1, mem_wr=1, mem_addr=latched d_addr, mem_data_in=d_wdata, d_done=1. Next state IDLE.
- IFILL/DFILL:
  - Issue phase: while issue_cnt<8, mem_enable=1, mem_wr=0, mem_addr=base+2*issue_cnt. issue_cnt increments each cycle, giving 8 consecutive issue cycles.
  - Return phase: each mem_data_valid asserts fill_write_data=1, fill_data=mem_data_out and fill_word_en=1<<ret_cnt in the same cycle, then ret_cnt increments. ret_cnt is 3 bits and wraps only at completion.
  - Completion: on the valid with ret_cnt==7, fill_write_tag=1 and the matching done pulse (i_done for IFILL, d_done for DFILL) assert in that same cycle. Next state IDLE and counters clear.
  - fill_sel = 0 in IFILL, 1 in DFILL, and holds its last value in IDLE.
  - mem_data_valid in IDLE or DWRITE is ignored.
- Nominal fill latency with 4-cycle memory: issues at cycles 0–7, returns at cycles 4–11, done at cycle 11, IDLE at cycle 12.
- Back-to-back: a request still held at the done cycle is re-arbitrated in IDLE the next cycle. There is never a zero-cycle IDLE.
- New requests arriving mid-transaction wait. They are never dropped as long as the requester holds them.
- busy=1 in every state except IDLE.

Test Plan:
- Reset: hold rst=0 for 2 cycles with i_miss=1 -> all outputs 0, state IDLE; release -> IFILL entered next cycle.
- I-fill i_addr=16'h1236 -> mem_addr sequence 1230,1232,…,123E. Returned words A0..A7 land on fill_word_en 01,02,…,80 with fill_sel=0. fill_write_tag and i_done pulse together on the A7 cycle, at cycle 11.
- Simultaneous i_miss, d_miss and d_wr (d_addr=16'h0040, d_wdata=16'hBEEF) -> DWRITE first (mem_wr=1, addr 0040, data BEEF, d_done), then DFILL of base 0040, then IFILL.
- Reset asserted at fill cycle 6 -> outputs clear next edge, no done pulse. The remaining mem_data_valid pulses produce no fill_write_data.
- d_wr raised during an IFILL -> waits until i_done; DWRITE occurs in the cycle after IFILL's return to IDLE.
